ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter: the CPU writes a command byte (e.g. 8'hED set-LEDs, 8'hF4 enable),
//  and the block runs the PS/2 inhibit/request-to-send/bit/ack sequence on the open-drain clock and data lines.
//  It is the outbound counterpart of the keyboard receiver and sits on an io_interface-style bus beside it.
//  It raises irq when a transfer finishes, whether it succeeded or failed.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_sync.sv | 40 ++++
 rtl/ps2_host_tx.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, register offsets and STATUS bit positions.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    BITS,
    STOP,
    ACK,
    WAIT_IDLE
  } tx_state_t;

  localparam int REG_TXDATA = 0;
  localparam int REG_STATUS = 1;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;
  localparam int STAT_OVR  = 3;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Conditions one raw PS/2 pin: 2-FF synchronizer, 4-sample majority filter with hold on ties,
// and a one-cycle pulse on each filtered falling edge.
module ps2_line_sync (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic pin,
  output logic filt,
  output logic fall
);

  logic       s1, s2;
  logic [2:0] hist;
  logic       filt_prev;
  logic [2:0] ones;

  assign ones = 3'(hist[0]) + 3'(hist[1]) + 3'(hist[2]) + 3'(s2);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      s1        <= 1'b1;
      s2        <= 1'b1;
      hist      <= 3'b111;
      filt      <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      s1        <= pin;
      s2        <= s1;
      hist      <= {hist[1:0], s2};
      filt_prev <= filt;
      // a 2/2 split keeps the previous level so a single glitch cannot toggle the output
      if (ones >= 3'd3)
        filt <= 1'b1;
      else if (ones <= 3'd1)
        filt <= 1'b0;
    end
  end

  assign fall = filt_prev & ~filt;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: bus-written command byte is sent with inhibit,
// request-to-send, 8 data bits, odd parity, stop and ack check; irq on completion.
//
// state     | meaning
// IDLE      | lines released, waiting for a TXDATA write
// INHIBIT   | clock held low for INHIBIT_CYCLES
// BITS      | start bit driven; data bits 0..7 then parity placed on device clock falls
// STOP      | release data on next fall (stop bit = 1)
// ACK       | sample device ack on next fall
// WAIT_IDLE | wait for both lines high, then report done
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR      = 16'hFF10,
  parameter int          INHIBIT_CYCLES = 5000,
  parameter int          TIMEOUT_CYCLES = 750000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [15:0] waddr,
  input  logic [15:0] wdata,
  input  logic        wenable,
  input  logic [15:0] raddr,
  output logic [15:0] rdata,
  output logic        irq,
  input  logic        reset_irq,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic        ps2_clk_oe,
  output logic        ps2_dat_oe
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  tx_state_t     state, state_n;
  logic [7:0]    tx_byte, tx_byte_n;
  logic          parity, parity_n;
  logic [3:0]    bit_idx, bit_idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          clk_oe_n, dat_oe_n;
  logic          busy, busy_n;
  logic          done, done_n;
  logic          err, err_n;
  logic          ovr, ovr_n;
  logic          irq_n;
  logic          complete;
  logic          wr_tx;
  logic          cur_bit;
  logic          in_xfer;
  logic          clk_filt, clk_fall;
  logic          dat_filt;
  logic          unused_dat_fall;
  logic          unused_wdata;
  logic [3:0]    status;

  ps2_line_sync u_clk_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .pin      (ps2_clk_in),
    .filt     (clk_filt),
    .fall     (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .pin      (ps2_dat_in),
    .filt     (dat_filt),
    .fall     (unused_dat_fall)
  );

  assign unused_wdata = ^wdata[15:8];

  assign wr_tx   = wenable && (waddr == BASE_ADDR + 16'(REG_TXDATA));
  assign cur_bit = bit_idx[3] ? parity : tx_byte[bit_idx[2:0]];
  assign in_xfer = (state == BITS) || (state == STOP) || (state == ACK) || (state == WAIT_IDLE);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tx_byte    <= '0;
      parity     <= 1'b0;
      bit_idx    <= '0;
      cnt        <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      ovr        <= 1'b0;
      irq        <= 1'b0;
    end else begin
      state      <= state_n;
      tx_byte    <= tx_byte_n;
      parity     <= parity_n;
      bit_idx    <= bit_idx_n;
      cnt        <= cnt_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
      busy       <= busy_n;
      done       <= done_n;
      err        <= err_n;
      ovr        <= ovr_n;
      irq        <= irq_n;
    end
  end

  always_comb begin
    state_n   = state;
    tx_byte_n = tx_byte;
    parity_n  = parity;
    bit_idx_n = bit_idx;
    cnt_n     = cnt;
    clk_oe_n  = ps2_clk_oe;
    dat_oe_n  = ps2_dat_oe;
    busy_n    = busy;
    done_n    = done;
    err_n     = err;
    ovr_n     = ovr;
    complete  = 1'b0;

    case (state)
      IDLE: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        if (wr_tx) begin
          tx_byte_n = wdata[7:0];
          parity_n  = odd_parity(wdata[7:0]);
          done_n    = 1'b0;
          err_n     = 1'b0;
          ovr_n     = 1'b0;
          busy_n    = 1'b1;
          cnt_n     = '0;
          clk_oe_n  = 1'b1;
          state_n   = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_oe_n = 1'b1;
        dat_oe_n = 1'b0;
        cnt_n    = cnt + 1'b1;
        if (cnt >= INH_LAST) begin
          clk_oe_n  = 1'b0;
          dat_oe_n  = 1'b1;
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = BITS;
        end
      end
      BITS: begin
        clk_oe_n = 1'b0;
        cnt_n    = cnt + 1'b1;
        if (clk_fall) begin
          dat_oe_n = ~cur_bit;
          if (bit_idx == 4'd8)
            state_n = STOP;
          else
            bit_idx_n = bit_idx + 1'b1;
        end
      end
      STOP: begin
        clk_oe_n = 1'b0;
        cnt_n    = cnt + 1'b1;
        if (clk_fall) begin
          dat_oe_n = 1'b0;
          state_n  = ACK;
        end
      end
      ACK: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        cnt_n    = cnt + 1'b1;
        if (clk_fall) begin
          err_n   = dat_filt;
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        cnt_n    = cnt + 1'b1;
        if (clk_filt && dat_filt) begin
          busy_n   = 1'b0;
          done_n   = 1'b1;
          complete = 1'b1;
          state_n  = IDLE;
        end
      end
      default: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        state_n  = IDLE;
      end
    endcase

    // a silent or stuck device must not hold the lines or the bus forever
    if (in_xfer && (cnt >= TO_LAST)) begin
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      err_n    = 1'b1;
      done_n   = 1'b1;
      busy_n   = 1'b0;
      complete = 1'b1;
      state_n  = IDLE;
    end

    if (wr_tx && busy)
      ovr_n = 1'b1;

    irq_n = irq;
    if (reset_irq)
      irq_n = 1'b0;
    if (complete)
      irq_n = 1'b1;
  end

  always_comb begin
    status            = '0;
    status[STAT_BUSY] = busy;
    status[STAT_DONE] = done;
    status[STAT_ERR]  = err;
    status[STAT_OVR]  = ovr;
  end

  assign rdata = (raddr == BASE_ADDR + 16'(REG_STATUS)) ? {12'b0, status} : 16'h0000;

endmodule
